// File: rtl/wb_exc_commit_if.sv
// wb_exc_commit_if: MEM-to-WB retire bundle with valid/allowin handshake
interface wb_exc_commit_if #(parameter int RF_AW = 5);
  logic             ms_to_ws_valid;
  logic             ws_allowin;
  logic [31:0]      ms_pc;
  logic [5:0]       ms_exc;
  logic [31:0]      ms_vaddr;
  logic             ms_ertn;
  logic             ms_csr_re;
  logic             ms_csr_we;
  logic [13:0]      ms_csr_num;
  logic [31:0]      ms_csr_wmask;
  logic [31:0]      ms_csr_wvalue;
  logic             ms_rf_we;
  logic [RF_AW-1:0] ms_rf_waddr;
  logic [31:0]      ms_rf_wdata;
  modport master (
    output ms_to_ws_valid, ms_pc, ms_exc, ms_vaddr, ms_ertn, ms_csr_re, ms_csr_we,
           ms_csr_num, ms_csr_wmask, ms_csr_wvalue, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
    input  ws_allowin
  );
  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_exc, ms_vaddr, ms_ertn, ms_csr_re, ms_csr_we,
           ms_csr_num, ms_csr_wmask, ms_csr_wvalue, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
    output ws_allowin
  );
endinterface

// File: rtl/wb_exc_commit.sv
// wb_exc_commit: writeback stage resolving exceptions/ERTN and holding the pre-IF redirect
module wb_exc_commit #(
  parameter int          RF_AW    = 5,
  parameter logic [31:0] PC_RESET = 32'h1c000000
) (
  input  logic             clk,
  input  logic             reset,
  wb_exc_commit_if.slave   ms,
  input  logic [31:0]      csr_rvalue,
  input  logic [31:0]      ex_entry,
  input  logic [31:0]      ertn_entry,
  output logic [13:0]      csr_num,
  output logic             csr_we,
  output logic [31:0]      csr_wmask,
  output logic [31:0]      csr_wvalue,
  output logic             csr_re,
  output logic             wb_ex,
  output logic [5:0]       wb_ecode,
  output logic [8:0]       wb_esubcode,
  output logic [31:0]      wb_vaddr,
  output logic [31:0]      wb_pc,
  output logic             ertn_flush,
  output logic             ws_flush,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [31:0]      redir_target,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [31:0]      debug_wb_pc
);
  logic             ws_valid_q, ws_valid_d, redir_valid_q, redir_valid_d;
  logic [31:0]      redir_target_q, redir_target_d, debug_pc_q;
  logic [31:0]      ws_pc_q, ws_vaddr_q, ws_csr_wmask_q, ws_csr_wvalue_q, ws_rf_wdata_q;
  logic [5:0]       ws_exc_q;
  logic             ws_ertn_q, ws_csr_re_q, ws_csr_we_q, ws_rf_we_q;
  logic [13:0]      ws_csr_num_q;
  logic [RF_AW-1:0] ws_rf_waddr_q;
  logic             live, has_exc, commit_ok;
  // wrong-path instructions behind an unaccepted redirect never commit
  always_comb begin
    live           = ws_valid_q & ~redir_valid_q;
    has_exc        = |ws_exc_q;
    commit_ok      = live & ~has_exc;
    wb_ex          = live & has_exc;
    ertn_flush     = commit_ok & ws_ertn_q;
    ws_flush       = wb_ex | ertn_flush | redir_valid_q;
    ms.ws_allowin  = 1'b1;
    ws_valid_d     = ms.ms_to_ws_valid & ms.ws_allowin & ~ws_flush;
    wb_ecode       = ~wb_ex       ? 6'h00 :
                     ws_exc_q[5]  ? 6'h00 :
                     ws_exc_q[4]  ? 6'h08 :
                     ws_exc_q[3]  ? 6'h0D :
                     ws_exc_q[2]  ? 6'h0B :
                     ws_exc_q[1]  ? 6'h0C : 6'h09;
    wb_esubcode    = 9'h0;
    wb_vaddr       = (~wb_ex | ws_exc_q[5]) ? 32'h0 :
                     ws_exc_q[4]  ? ws_pc_q :
                     |ws_exc_q[3:1] ? 32'h0 : ws_vaddr_q;
    wb_pc          = ws_pc_q;
    csr_num        = ws_csr_num_q;
    csr_we         = commit_ok & ws_csr_we_q;
    csr_re         = commit_ok & ws_csr_re_q;
    csr_wmask      = ws_csr_wmask_q;
    csr_wvalue     = ws_csr_wvalue_q;
    rf_we          = commit_ok & ws_rf_we_q;
    rf_waddr       = ws_rf_waddr_q;
    rf_wdata       = csr_re ? csr_rvalue : ws_rf_wdata_q;
    redir_valid_d  = wb_ex | ertn_flush | (redir_valid_q & ~redir_ready);
    redir_target_d = wb_ex ? ex_entry : ertn_flush ? ertn_entry : redir_target_q;
    redir_valid    = redir_valid_q;
    redir_target   = redir_target_q;
    debug_wb_pc    = debug_pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q      <= 1'b0;
      redir_valid_q   <= 1'b0;
      redir_target_q  <= 32'h0;
      debug_pc_q      <= PC_RESET;
      ws_pc_q         <= 32'h0;
      ws_exc_q        <= 6'h0;
      ws_vaddr_q      <= 32'h0;
      ws_ertn_q       <= 1'b0;
      ws_csr_re_q     <= 1'b0;
      ws_csr_we_q     <= 1'b0;
      ws_csr_num_q    <= 14'h0;
      ws_csr_wmask_q  <= 32'h0;
      ws_csr_wvalue_q <= 32'h0;
      ws_rf_we_q      <= 1'b0;
      ws_rf_waddr_q   <= '0;
      ws_rf_wdata_q   <= 32'h0;
    end else begin
      ws_valid_q      <= ws_valid_d;
      redir_valid_q   <= redir_valid_d;
      redir_target_q  <= redir_target_d;
      if (ws_valid_d) begin
        debug_pc_q      <= ms.ms_pc;
        ws_pc_q         <= ms.ms_pc;
        ws_exc_q        <= ms.ms_exc;
        ws_vaddr_q      <= ms.ms_vaddr;
        ws_ertn_q       <= ms.ms_ertn;
        ws_csr_re_q     <= ms.ms_csr_re;
        ws_csr_we_q     <= ms.ms_csr_we;
        ws_csr_num_q    <= ms.ms_csr_num;
        ws_csr_wmask_q  <= ms.ms_csr_wmask;
        ws_csr_wvalue_q <= ms.ms_csr_wvalue;
        ws_rf_we_q      <= ms.ms_rf_we;
        ws_rf_waddr_q   <= ms.ms_rf_waddr;
        ws_rf_wdata_q   <= ms.ms_rf_wdata;
      end
    end
  end
endmodule
